// File: rtl/imem_load_pkg.sv
// rtl/imem_load_pkg.sv - shared states and sizing helpers for the imem loader
package imem_load_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        LOAD,
        WRITE,
        DONE,
        ERROR
    } state_t;

    localparam int N_DEFAULT      = 32;
    localparam int BYTES_PER_WORD = N_DEFAULT / 8;
    localparam int BCW            = $clog2(BYTES_PER_WORD);

    // A one-byte word still needs a one-bit counter to keep vectors legal.
    function automatic int cnt_width(input int bytes);
        return (bytes > 1) ? $clog2(bytes) : 1;
    endfunction

endpackage

// File: rtl/imem_loader_word_assembler.sv
// rtl/imem_loader_word_assembler.sv - little-endian byte-to-word assembler
module word_assembler
    import imem_load_pkg::*;
#(
    parameter int N = N_DEFAULT
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [7:0]   i_byte,
    input  logic         i_load,
    input  logic         i_clear,
    output logic [N-1:0] o_word,
    output logic         o_last_byte
);

    localparam int BPW = N / 8;
    localparam int CW  = cnt_width(BPW);

    logic [N-1:0]  r_word;
    logic [CW-1:0] r_cnt;

    assign o_word      = r_word;
    assign o_last_byte = (r_cnt == CW'(BPW - 1));

    always_ff @(posedge clock) begin
        if (reset || i_clear) begin
            r_word <= '0;
            r_cnt  <= '0;
        end else if (i_load) begin
            for (int k = 0; k < BPW; k++) begin
                if (r_cnt == CW'(k)) begin
                    r_word[8*k +: 8] <= i_byte;
                end
            end
            r_cnt <= o_last_byte ? '0 : r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot byte stream to instruction memory writer with core hold
module imem_loader
    import imem_load_pkg::*;
#(
    parameter int n      = 32,
    parameter int AW     = 5,
    parameter int NWORDS = 32
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic [7:0]    rx_data,
    input  logic          rx_valid,
    output logic          rx_ready,
    output logic          we,
    output logic [AW-1:0] waddr,
    output logic [n-1:0]  wdata,
    output logic          busy,
    output logic          done,
    output logic          error,
    output logic          cpu_hold
);

    localparam logic [AW:0] IDX_ONE = (AW+1)'(1);

    state_t      r_state;
    logic [AW:0] r_len;
    logic [AW:0] r_index;
    logic        r_rx_ready;
    logic        r_we;
    logic        r_busy;
    logic        r_done;
    logic        r_error;
    logic        r_cpu_hold;

    logic        w_xfer;
    logic        w_idle_like;
    logic        w_clear;
    logic        w_load;
    logic        w_last_byte;
    logic [31:0] w_len32;
    logic        w_len_ok;
    logic        w_last_word;
    logic [n-1:0] w_word;

    assign w_xfer      = rx_valid && r_rx_ready;
    assign w_idle_like = (r_state == IDLE) || (r_state == DONE) || (r_state == ERROR);
    assign w_clear     = start && w_idle_like;
    assign w_load      = w_xfer && (r_state == LOAD);
    assign w_len32     = {24'd0, rx_data};
    assign w_len_ok    = (rx_data != 8'd0) && (w_len32 <= 32'(NWORDS));
    assign w_last_word = (r_index == r_len - IDX_ONE);

    word_assembler #(
        .N(n)
    ) u_asm (
        .clock       (clock),
        .reset       (reset),
        .i_byte      (rx_data),
        .i_load      (w_load),
        .i_clear     (w_clear),
        .o_word      (w_word),
        .o_last_byte (w_last_byte)
    );

    assign rx_ready = r_rx_ready;
    assign we       = r_we;
    assign waddr    = r_index[AW-1:0];
    assign wdata    = w_word;
    assign busy     = r_busy;
    assign done     = r_done;
    assign error    = r_error;
    assign cpu_hold = r_cpu_hold;

    // Flags are assigned alongside each transition so they reflect the state being entered.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= IDLE;
            r_len      <= '0;
            r_index    <= '0;
            r_rx_ready <= 1'b0;
            r_we       <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_cpu_hold <= 1'b1;
        end else begin
            r_we <= 1'b0;
            case (r_state)
                IDLE, DONE, ERROR: begin
                    if (start) begin
                        r_state    <= HDR;
                        r_index    <= '0;
                        r_rx_ready <= 1'b1;
                        r_busy     <= 1'b1;
                        r_done     <= 1'b0;
                        r_error    <= 1'b0;
                        r_cpu_hold <= 1'b1;
                    end
                end
                HDR: begin
                    if (w_xfer) begin
                        if (w_len_ok) begin
                            r_len   <= w_len32[AW:0];
                            r_state <= LOAD;
                        end else begin
                            r_state    <= ERROR;
                            r_rx_ready <= 1'b0;
                            r_busy     <= 1'b0;
                            r_error    <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (w_xfer && w_last_byte) begin
                        r_state    <= WRITE;
                        r_rx_ready <= 1'b0;
                        r_we       <= 1'b1;
                    end
                end
                WRITE: begin
                    if (w_last_word) begin
                        r_state    <= DONE;
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
                        r_cpu_hold <= 1'b0;
                    end else begin
                        r_state    <= LOAD;
                        r_index    <= r_index + IDX_ONE;
                        r_rx_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_rx_ready <= 1'b0;
                    r_busy     <= 1'b0;
                    r_cpu_hold <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - randomized scoreboard bench for imem_loader
module tb_imem_loader;

    localparam int N  = 32;
    localparam int AW = 5;
    localparam int NW = 32;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [7:0]    rx_data = 8'd0;
    logic          rx_valid = 1'b0;
    logic          rx_ready;
    logic          we;
    logic [AW-1:0] waddr;
    logic [N-1:0]  wdata;
    logic          busy;
    logic          done;
    logic          error;
    logic          cpu_hold;

    imem_loader #(.n(N), .AW(AW), .NWORDS(NW)) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .cpu_hold (cpu_hold)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [AW-1:0] addr;
        logic [N-1:0]  data;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    logic prev_hs = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: every write must follow a handshake and match the next scoreboard entry.
    always @(negedge clock) begin
        if (we) begin
            wr_t e;
            check("we_follows_handshake", {63'd0, prev_hs}, 64'd1);
            check("rx_ready_low_during_we", {63'd0, rx_ready}, 64'd0);
            check("write_expected", {63'd0, exp_q.size() != 0}, 64'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("waddr", {59'd0, waddr}, {59'd0, e.addr});
                check("wdata", {32'd0, wdata}, {32'd0, e.data});
            end
        end
        prev_hs = rx_valid && rx_ready;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        logic hs;
        int   budget;
        rx_valid = 1'b0;
        repeat (gap) begin
            rx_data = 8'($urandom);
            @(posedge clock); #1;
        end
        rx_valid = 1'b1;
        rx_data  = b;
        hs       = 1'b0;
        budget   = 0;
        while (!hs && budget < 200) begin
            hs = rx_ready;
            @(posedge clock); #1;
            budget++;
        end
        check("byte_accepted", {63'd0, hs}, 64'd1);
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
    endtask

    task automatic send_words(input logic [N-1:0] words[$], input int gmin, input int gmax);
        for (int w = 0; w < words.size(); w++) begin
            for (int k = 0; k < N/8; k++) begin
                send_byte(words[w][8*k +: 8], $urandom_range(gmax, gmin));
            end
            exp_q.push_back('{addr: AW'(w), data: words[w]});
        end
    endtask

    task automatic load_image(input int len, input int gmin, input int gmax);
        logic [N-1:0] words[$];
        for (int i = 0; i < len; i++) words.push_back(N'($urandom));
        send_byte(8'(len), $urandom_range(gmax, gmin));
        send_words(words, gmin, gmax);
    endtask

    task automatic wait_done(input string name);
        int budget = 0;
        while (!done && budget < 50) begin
            @(posedge clock); #1;
            budget++;
        end
        check({name, "_done"}, {61'd0, done, cpu_hold, busy}, 64'b100);
    endtask

    task automatic idle_offers(input string name, input int cycles);
        rx_valid = 1'b1;
        repeat (cycles) begin
            rx_data = 8'($urandom);
            @(negedge clock);
            check({name, "_no_ready"}, {62'd0, rx_ready, we}, 64'd0);
        end
        @(posedge clock); #1;
        rx_valid = 1'b0;
    endtask

    initial begin
        logic [N-1:0] ws[$];

        // Reset then idle, with bytes offered that must never be taken
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        check("reset_waddr_wdata", {27'd0, waddr, wdata}, 64'd0);
        rx_valid = 1'b1;
        repeat (10) begin
            rx_data = 8'($urandom);
            @(negedge clock);
            check("idle_outputs", {58'd0, cpu_hold, done, busy, rx_ready, we, error}, 64'b100000);
        end
        @(posedge clock); #1;
        rx_valid = 1'b0;

        // Single word, back-to-back bytes
        pulse_start();
        check("hdr_busy_ready", {61'd0, busy, rx_ready, cpu_hold}, 64'b111);
        send_byte(8'h01, 0);
        ws = '{32'h00500513};
        send_words(ws, 0, 0);
        check("single_we_latency", {63'd0, we}, 64'd1);
        @(posedge clock); #1;
        check("single_done_release", {62'd0, done, cpu_hold}, 64'b10);

        // Three words with stalls; a start pulse mid-load must be ignored
        pulse_start();
        send_byte(8'd3, 1);
        pulse_start();
        check("start_ignored_busy", {63'd0, busy}, 64'd1);
        ws.delete();
        for (int i = 0; i < 3; i++) ws.push_back(N'($urandom));
        send_words(ws, 1, 3);
        wait_done("three");

        // Bad headers, then a full-size image
        pulse_start();
        send_byte(8'h00, 0);
        check("len0_error", {60'd0, error, busy, cpu_hold, done}, 64'b1010);
        idle_offers("err0", 4);
        pulse_start();
        check("err_restart_clears", {62'd0, error, busy}, 64'b01);
        send_byte(8'h21, 2);
        check("len33_error", {60'd0, error, busy, cpu_hold, done}, 64'b1010);
        pulse_start();
        load_image(NW, 0, 1);
        wait_done("full");

        // Reset mid-load after six data bytes
        pulse_start();
        send_byte(8'd4, 0);
        ws.delete();
        ws.push_back(N'($urandom));
        send_words(ws, 0, 1);
        send_byte(8'($urandom), 0);
        send_byte(8'($urandom), 1);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        check("midreset_state", {59'd0, cpu_hold, busy, done, rx_ready, we}, 64'b10000);
        idle_offers("midreset", 5);
        // Simultaneous start and reset: reset wins
        reset = 1'b1;
        start = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        start = 1'b0;
        check("reset_beats_start", {62'd0, busy, rx_ready}, 64'd0);
        pulse_start();
        load_image(1, 0, 2);
        wait_done("after_reset");

        // Reload from DONE
        pulse_start();
        check("reload_hold", {60'd0, cpu_hold, done, busy, rx_ready}, 64'b1011);
        load_image(2, 0, 2);
        wait_done("reload");

        repeat (3) @(posedge clock);
        #1;
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
